noise_word_packer: RTL and testbench

Downstream consumer of the serial LFSR noise generator. Collects the one-bit-per-clock random stream into WIDTH-bit noise samples and buffers them in a small show-ahead FIFO. Samples are presented to the audio/DAC path on a valid/ready handshake. Dropped words are counted so overflow is observable.

---
 rtl/noise_word_packer.sv | 127 ++++++++++++
 tb/tb_noise_word_packer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_word_packer.sv
// ---------------------------------------------------------------------------
// noise_word_packer
//
// Packs a serial random bit stream (one qualified bit per clock) into
// WIDTH-bit noise samples and buffers them in a DEPTH-entry show-ahead FIFO
// that is drained over a valid/ready handshake. If a completed word cannot be
// stored, it is dropped. Each drop sets a sticky overflow flag and bumps a
// saturating counter.
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset         asynchronous, active-high; clears all state
//   bit_in        serial random bit
//   bit_en        bit_in is valid this cycle
//   flush         discard the partially assembled word (wins over bit_en)
//   clr_overflow  clear overflow and drop_count (a same-cycle drop wins)
//   sample        FIFO head word, 0 while sample_valid is low
//   sample_valid  FIFO is non-empty
//   sample_ready  consumer accepts the head word this cycle
//   fill          number of words held, 0..DEPTH
//   overflow      sticky: a completed word was dropped
//   drop_count    number of dropped words, saturates at 0xFFFF
// ---------------------------------------------------------------------------
module noise_word_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             flush,
    input  logic             clr_overflow,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [AW:0]      fill,
    output logic             overflow,
    output logic [15:0]      drop_count
);

    localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] word;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic [WIDTH-1:0] next_word;
    logic             word_done;
    logic             pop;
    logic             push;
    logic             drop;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    always_comb begin
        next_word = {word[WIDTH-2:0], bit_in};
        word_done = bit_en && !flush && (bcnt == LAST_BIT);
        pop       = sample_valid && sample_ready;
        push      = word_done && ((fill != FULL) || pop);
        drop      = word_done && (fill == FULL) && !pop;
    end

    assign sample_valid = (fill != '0);
    assign sample       = sample_valid ? mem[rd_ptr] : '0;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
            bcnt <= '0;
        end else if (flush) begin
            word <= '0;
            bcnt <= '0;
        end else if (bit_en) begin
            word <= next_word;
            bcnt <= word_done ? '0 : bcnt + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible
    // because sample is gated by sample_valid, and the pointers and fill are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= next_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // A drop in the same cycle as clr_overflow leaves a count of one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow)
                drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_noise_word_packer.sv
// ---------------------------------------------------------------------------
// Testbench for noise_word_packer (WIDTH=8, DEPTH=4).
// A reference model built from a bit queue and a word queue predicts every
// output after every clock edge. A vector table covers basic assembly, and
// hand-written sequences cover overflow, full+pop, reset, saturation and clear.
// ---------------------------------------------------------------------------
module tb_noise_word_packer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             bit_in;
    logic             bit_en;
    logic             flush;
    logic             clr_overflow;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             sample_ready;
    logic [AW:0]      fill;
    logic             overflow;
    logic [15:0]      drop_count;

    noise_word_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_en       (bit_en),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fill         (fill),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_bits[$];   // bits of the word being assembled, oldest first
    logic [WIDTH-1:0] m_q[$];      // buffered words, head first
    bit               m_ovf;
    int               m_drops;

    function automatic void model_clear();
        m_bits.delete();
        m_q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endfunction

    // Applies the current inputs to the model as one clock edge.
    function automatic void model_step();
        bit               do_pop;
        bit               done;
        bit               dropped;
        int               val;
        logic [WIDTH-1:0] w;
        do_pop  = (m_q.size() != 0) && sample_ready;
        done    = 1'b0;
        dropped = 1'b0;
        w       = '0;
        if (flush) begin
            m_bits.delete();
        end else if (bit_en) begin
            m_bits.push_back(bit_in ? 1 : 0);
            if (m_bits.size() == WIDTH) begin
                val = 0;
                foreach (m_bits[i]) val = val * 2 + m_bits[i];
                w    = val[WIDTH-1:0];
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else dropped = 1'b1;
        end
        if (dropped) begin
            m_ovf   = 1'b1;
            m_drops = clr_overflow ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
        end else if (clr_overflow) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] es;
        es = (m_q.size() != 0) ? m_q[0] : '0;
        check({tag, ".sample"},       32'(sample),       32'(es));
        check({tag, ".sample_valid"}, 32'(sample_valid), 32'(m_q.size() != 0));
        check({tag, ".fill"},         32'(fill),         32'(m_q.size()));
        check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        check({tag, ".drop_count"},   32'(drop_count),   32'(m_drops));
    endtask

    // One clock: model advances with the pre-edge inputs, DUT sampled 1 ns after the edge.
    task automatic tick(input bit do_check, input string tag = "cyc");
        model_step();
        @(posedge clk);
        #1;
        if (do_check) check_all(tag);
    endtask

    task automatic idle_inputs();
        bit_in = 1'b0; bit_en = 1'b0; flush = 1'b0;
        clr_overflow = 1'b0; sample_ready = 1'b0;
    endtask

    // Sends one word MSB first; ready/clear can be raised on the final bit only.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy_last, input bit clr_last);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            bit_in       = w[i];
            bit_en       = 1'b1;
            sample_ready = (i == 0) && rdy_last;
            clr_overflow = (i == 0) && clr_last;
            tick(1, "send");
        end
        idle_inputs();
    endtask

    task automatic drain();
        idle_inputs();
        sample_ready = 1'b1;
        repeat (DEPTH + 1) tick(1, "drain");
        sample_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             bit_in;
        logic             bit_en;
        logic             flush;
        logic             ready;
        logic [WIDTH-1:0] exp_sample;
        logic             exp_valid;
        logic [AW:0]      exp_fill;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic bi, input logic en, input logic fl, input logic rdy,
                                input logic [WIDTH-1:0] es, input logic ev, input logic [AW:0] ef);
        vec_t v;
        v.bit_in = bi; v.bit_en = en; v.flush = fl; v.ready = rdy;
        v.exp_sample = es; v.exp_valid = ev; v.exp_fill = ef;
        vecs.push_back(v);
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] pat;

        // Assembly of 0xAB: bits 1,0,1,0,1,0,1,1 with no consumer.
        pat = 8'hAB;
        for (int i = WIDTH - 1; i > 0; i--) add(pat[i], 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        add(pat[0], 1'b1, 1'b0, 1'b0, 8'hAB, 1'b1, 3'd1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0);
        // Three bits, then flush with a live bit, then eight ones with gaps.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        add(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 16; k++) begin
            if (k < 14) add(1'b1, (k % 2) == 0, 1'b0, 1'b0, '0, 1'b0, '0);
            else        add(1'b1, (k % 2) == 0, 1'b0, 1'b0, 8'hFF, 1'b1, 3'd1);
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0);

        // ---------------- reset ----------------
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check_all("reset");
        repeat (10) tick(1, "idle");

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            bit_in       = vecs[i].bit_in;
            bit_en       = vecs[i].bit_en;
            flush        = vecs[i].flush;
            sample_ready = vecs[i].ready;
            tick(0);
            check($sformatf("vec%0d.sample", i), 32'(sample),       32'(vecs[i].exp_sample));
            check($sformatf("vec%0d.valid", i),  32'(sample_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d.fill", i),   32'(fill),         32'(vecs[i].exp_fill));
        end
        idle_inputs();
        tick(1, "post_table");

        // ---------------- overflow ----------------
        for (int k = 1; k <= 5; k++) send_word(WIDTH'(k), 1'b0, 1'b0);
        check("ovf.fill",  32'(fill),       32'd4);
        check("ovf.flag",  32'(overflow),   32'd1);
        check("ovf.count", 32'(drop_count), 32'd1);
        sample_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf.pop%0d", k), 32'(sample), 32'(k));
            tick(1, "ovf_pop");
        end
        check("ovf.empty", 32'(sample_valid), 32'd0);
        idle_inputs();
        clr_overflow = 1'b1;
        tick(1, "clr");
        idle_inputs();

        // ---------------- full with simultaneous pop ----------------
        for (int k = 1; k <= 4; k++) send_word(WIDTH'(k), 1'b0, 1'b0);
        send_word(8'd5, 1'b1, 1'b0);
        check("fullpop.fill",  32'(fill),     32'd4);
        check("fullpop.flag",  32'(overflow), 32'd0);
        sample_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("fullpop.pop%0d", k), 32'(sample), 32'(k));
            tick(1, "fullpop_pop");
        end
        check("fullpop.empty", 32'(sample_valid), 32'd0);
        idle_inputs();

        // ---------------- asynchronous reset mid-word ----------------
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b0);
        bit_en = 1'b1; bit_in = 1'b1;
        repeat (3) tick(1, "partial");
        idle_inputs();
        reset = 1'b1;
        #2;
        check("areset.sample", 32'(sample),       32'd0);
        check("areset.valid",  32'(sample_valid), 32'd0);
        check("areset.fill",   32'(fill),         32'd0);
        check("areset.ovf",    32'(overflow),     32'd0);
        check("areset.count",  32'(drop_count),   32'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_word(8'hC3, 1'b0, 1'b0);
        check("areset.fresh", 32'(sample), 32'hC3);
        drain();

        // ---------------- saturation and clear ----------------
        for (int k = 0; k < DEPTH; k++) send_word(WIDTH'(8'h10 + k), 1'b0, 1'b0);
        send_word(8'hAA, 1'b0, 1'b0);
        check("sat.first", 32'(drop_count), 32'd1);
        force dut.drop_count = 16'hFFFE;
        #1;
        release dut.drop_count;
        m_drops = 65534;
        send_word(8'hAA, 1'b0, 1'b0);
        check("sat.reach", 32'(drop_count), 32'hFFFF);
        send_word(8'hAB, 1'b0, 1'b0);
        check("sat.hold",  32'(drop_count), 32'hFFFF);
        check("sat.flag",  32'(overflow),   32'd1);
        clr_overflow = 1'b1;
        tick(1, "clr_only");
        idle_inputs();
        check("clr.flag",  32'(overflow),   32'd0);
        check("clr.count", 32'(drop_count), 32'd0);
        send_word(8'hEE, 1'b0, 1'b1);
        check("clrdrop.flag",  32'(overflow),   32'd1);
        check("clrdrop.count", 32'(drop_count), 32'd1);
        drain();

        // ---------------- randomized ----------------
        for (int n = 0; n < 3000; n++) begin
            bit_in       = 1'($urandom);
            bit_en       = ($urandom_range(99) < 75);
            flush        = ($urandom_range(99) < 3);
            clr_overflow = ($urandom_range(99) < 3);
            sample_ready = ($urandom_range(99) < ((n / 500) % 2 == 0 ? 40 : 10));
            tick(1, "rand");
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
